// File: rtl/arb2_mux_ctrl_pkg.sv
// arb2_pkg -- shared definitions for the two-requester arbitrating mux.
//   state_t : grant FSM encoding (IDLE / G0 / G1), fixed so checkers and
//             debug tooling can decode state_dbg directly.
//   CNT_W   : width of the per-grant beat counter.
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/arb2_mux_ctrl_mux.sv
// mux2to1_vec -- WIDTH-bit 2-to-1 select.
//   i0, i1 : data inputs
//   s0     : select (0 -> i0, 1 -> i1)
//   y      : selected data, purely combinational
module mux2to1_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);

  assign y = s0 ? i1 : i0;

endmodule

// File: rtl/arb2_mux_ctrl.sv
// arb2_mux_ctrl -- two-requester arbiter driving a shared output channel.
// A requester is granted the channel and keeps it until it drops its
// request or completes MAX_HOLD accepted transfers; ties are broken in
// favour of the requester that was not served last.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   req0/req1       : requests; d0/d1 : requester data
//   ack0/ack1       : transfer accepted from requester 0 / 1 this cycle
//   out_valid       : channel holds valid data; out_data : granted data
//   out_ready       : downstream accepts data this cycle
//   sel             : current mux select (1 only while requester 1 owns)
//   state_dbg       : current FSM state for debug / assertion binding
//   lock0/lock1     : only with ARB2_MUX_CTRL_LOCK_EN defined; while the
//                     owner's lock is high the MAX_HOLD release is skipped
//
// Handshake: a beat transfers on any cycle where out_valid && out_ready;
// that same cycle the owning requester sees its ack. Requesters keep req
// and data stable until ack; dropping req without ack is a release.
//
// MAX_HOLD legal range: 1..255.
module arb2_mux_ctrl
  import arb2_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
`ifdef ARB2_MUX_CTRL_LOCK_EN
  input  logic             lock0,
  input  logic             lock1,
`endif
  output logic             ack0,
  output logic             ack1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output state_t           state_dbg
);

  localparam logic [CNT_W:0] HOLD_LIM = (CNT_W + 1)'(MAX_HOLD);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_srv;   // requester released most recently

  logic             granted;    // index of owner when state is G0/G1
  logic             req_own;
  logic             req_oth;
  logic             lock_own;
  logic             xfer;
  logic [CNT_W:0]   cnt_next;   // one extra bit so MAX_HOLD=255 cannot wrap
  logic [CNT_W-1:0] cnt_inc;
  logic             hold_hit;

  assign granted = (state == G1);
  assign req_own = granted ? req1 : req0;
  assign req_oth = granted ? req0 : req1;

`ifdef ARB2_MUX_CTRL_LOCK_EN
  assign lock_own = granted ? lock1 : lock0;
`else
  assign lock_own = 1'b0;
`endif

  // Outputs are masked while rst_n is low so nothing leaks from a grant
  // that is being torn down by reset.
  assign sel       = rst_n & (state == G1);
  assign out_valid = rst_n & (((state == G0) & req0) | ((state == G1) & req1));
  assign xfer      = out_valid & out_ready;
  assign ack0      = xfer & (state == G0);
  assign ack1      = xfer & (state == G1);
  assign state_dbg = state;

  // Counter saturates at MAX_HOLD so a locked owner can keep streaming;
  // the first transfer after the lock drops then releases immediately.
  assign cnt_next = {1'b0, cnt} + 1'b1;
  assign cnt_inc  = (cnt_next > HOLD_LIM) ? HOLD_LIM[CNT_W-1:0]
                                          : cnt_next[CNT_W-1:0];
  assign hold_hit = xfer & (cnt_next >= HOLD_LIM) & ~lock_own;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_srv <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          // On a tie requester 0 wins unless it was the last one served.
          if (req0 && (!req1 || last_srv)) state <= G0;
          else if (req1)                   state <= G1;
        end
        G0, G1: begin
          if (!req_own || hold_hit) begin
            last_srv <= granted;
            cnt      <= '0;
            if (req_oth)      state <= granted ? G0 : G1;
            else if (req_own) state <= state;   // MAX_HOLD with no rival
            else              state <= IDLE;
          end else if (xfer) begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  mux2to1_vec #(.WIDTH(WIDTH)) u_mux (
    .i0 (d0),
    .i1 (d1),
    .s0 (sel),
    .y  (out_data)
  );

endmodule
